// File: rtl/alu32_bist.sv
// ALU self-test sequencer: sweeps opcodes x pseudo-random operands, folds out/S into a MISR, compares to GOLDEN.
// Latency: 2 cycles per vector, done 2V+2 edges after start. No backpressure; start ignored while busy.
// ALU_BIST_CORNER_EN: when defined, each opcode runs 4 fixed corner vectors before its LFSR vectors.
module alu32_bist #(
    parameter int             N        = 32,
    parameter int             OP_W     = 5,
    parameter int             NUM_OPS  = 9,
    parameter int             PATTERNS = 16,
    parameter logic [N-1:0]   SEED     = 32'hACE12468,
    parameter logic [N-1:0]   POLY     = 32'h80200003,
    parameter logic [N-1:0]   GOLDEN   = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N-1:0]    a_out,
    output logic [N-1:0]    b_out,
    output logic [OP_W-1:0] op_out,
    input  logic [N-1:0]    alu_out,
    input  logic [3:0]      alu_s,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N-1:0]    signature
);

`ifdef ALU_BIST_CORNER_EN
    localparam int NC = 4;
`else
    localparam int NC = 0;
`endif
    localparam int VPO   = PATTERNS + NC;
    localparam int PAT_W = $clog2(VPO + 1);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_COMPARE, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      lfsr, misr;
    logic [OP_W-1:0]   op_cnt;
    logic [PAT_W-1:0]  pat_cnt;
    logic              accept, drive_en, cap_en, cmp_en, fin_en;
    logic              last_vec, last_pat, is_corner;
    logic [N-1:0]      corner_a, corner_b, vec_a, vec_b;

    function automatic logic [N-1:0] step(input logic [N-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

`ifdef ALU_BIST_CORNER_EN
    assign is_corner = (pat_cnt < PAT_W'(NC));
    always_comb begin
        corner_a = '0;
        corner_b = '0;
        case (pat_cnt[1:0])
            2'd0: begin corner_a = '0; corner_b = '0; end
            2'd1: begin corner_a = '1; corner_b = '1; end
            2'd2: begin corner_a = {1'b1, {(N-4){1'b0}}, 3'b100}; corner_b = N'(1); end
            default: begin corner_a = N'(7); corner_b = N'(2); end
        endcase
    end
`else
    assign is_corner = 1'b0;
    assign corner_a  = '0;
    assign corner_b  = '0;
`endif

    // b operand is a rotated, scrambled copy of the LFSR so a and b are decorrelated
    assign vec_a = is_corner ? corner_a : lfsr;
    assign vec_b = is_corner ? corner_b : ({lfsr[N-8:0], lfsr[N-1:N-7]} ^ {(N/8){8'h5A}});

    assign last_pat = (pat_cnt == PAT_W'(VPO - 1));
    assign last_vec = last_pat && (op_cnt == OP_W'(NUM_OPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_DRIVE;
            S_DRIVE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = last_vec ? S_COMPARE : S_DRIVE;
            S_COMPARE: state_nxt = S_DONE;
            S_DONE:    if (start) state_nxt = S_DRIVE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept   = start && (state == S_IDLE || state == S_DONE);
        drive_en = (state == S_DRIVE);
        cap_en   = (state == S_CAPTURE);
        cmp_en   = (state == S_COMPARE);
        fin_en   = (state == S_DONE) && !start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out   <= '0;
            b_out   <= '0;
            op_out  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            lfsr    <= SEED;
            misr    <= '0;
            op_cnt  <= '0;
            pat_cnt <= '0;
        end else begin
            if (accept) begin
                done    <= 1'b0;
                pass    <= 1'b0;
                busy    <= 1'b1;
                misr    <= '0;
                lfsr    <= SEED;
                op_cnt  <= '0;
                pat_cnt <= '0;
            end
            if (drive_en) begin
                a_out  <= vec_a;
                b_out  <= vec_b;
                op_out <= op_cnt;
            end
            if (cap_en) begin
                misr <= step(misr) ^ alu_out ^ {{(N-4){1'b0}}, alu_s};
                if (!is_corner) lfsr <= step(lfsr);
                if (last_pat) begin
                    pat_cnt <= '0;
                    op_cnt  <= op_cnt + 1'b1;
                end else begin
                    pat_cnt <= pat_cnt + 1'b1;
                end
            end
            if (cmp_en) pass <= (misr == GOLDEN);
            if (fin_en) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign signature = misr;

endmodule

// File: tb/tb_alu32_bist.sv
// Scoreboarded bench for alu32_bist with a behavioural ALU and a loop-level signature model.
module tb_alu32_bist;
    localparam logic [31:0] SEED = 32'hACE12468;
    localparam logic [31:0] POLY = 32'h80200003;
`ifdef ALU_BIST_CORNER_EN
    localparam int NC = 4;
`else
    localparam int NC = 0;
`endif
    localparam int NOPS = 9;
    localparam int NPAT = 16;
    localparam int V    = NOPS * (NPAT + NC);
    localparam int LAT  = 2 * V + 2;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    function automatic logic [31:0] bmix(input logic [31:0] x);
        return ((x << 7) | (x >> 25)) ^ 32'h5A5A5A5A;
    endfunction

    // Behavioural ALU: returns {flags, result}; flags = {neg, zero, carry, parity}
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op, input bit fault);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        w = 33'd0;
        c = 1'b0;
        case (op)
            5'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
            5'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = a << b[4:0];
            5'd6: r = a >> b[4:0];
            5'd7: r = $unsigned($signed(a) >>> b[4:0]);
            5'd8: r = {31'd0, $signed(a) < $signed(b)};
            default: r = 32'd0;
        endcase
        return {r[31], r == 32'd0, c, ^r, (fault ? (r & 32'hFFFFFFFE) : r)};
    endfunction

    function automatic logic [31:0] model_sig(input bit fault);
        logic [31:0] lfsr, misr, a, b;
        logic [35:0] r;
        lfsr = SEED;
        misr = 32'd0;
        for (int op = 0; op < NOPS; op++) begin
            for (int p = 0; p < NPAT + NC; p++) begin
                if (p < NC) begin
                    case (p)
                        0: begin a = 32'h0;        b = 32'h0;        end
                        1: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
                        2: begin a = 32'h80000004; b = 32'h1;        end
                        default: begin a = 32'h7;  b = 32'h2;        end
                    endcase
                end else begin
                    a = lfsr;
                    b = bmix(lfsr);
                    lfsr = lstep(lfsr);
                end
                r = alu_model(a, b, 5'(op), fault);
                misr = lstep(misr) ^ r[31:0] ^ {28'd0, r[35:32]};
            end
        end
        return misr;
    endfunction

    localparam logic [31:0] GOLD = model_sig(1'b0);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_out, b_out, alu_out, signature;
    logic [4:0]  op_out;
    logic [3:0]  alu_s;
    logic        busy, done, pass;
    bit          fault;
    logic [35:0] alu_res;

    always #5 clk = ~clk;

    always_comb alu_res = alu_model(a_out, b_out, op_out, fault);
    assign alu_out = alu_res[31:0];
    assign alu_s   = alu_res[35:32];

    alu32_bist #(.GOLDEN(GOLD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out), .op_out(op_out),
        .alu_out(alu_out), .alu_s(alu_s),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    typedef struct {
        logic [31:0] sig;
        logic        pss;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    logic done_d   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every rising done is matched against the oldest outstanding run
    always @(negedge clk) begin
        if (rst_n && done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected_done: done rose with no run outstanding");
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_signature", signature, mon_e.sig);
                check("sb_pass", {31'd0, pass}, {31'd0, mon_e.pss});
                check("sb_busy_low", {31'd0, busy}, 32'd0);
                check("sb_latency", 32'(cyc - start_cyc), 32'(LAT));
            end
        end
        done_d <= done;
    end

    task automatic run(input bit flt);
        exp_t e;
        fault = flt;
        e.sig = model_sig(flt);
        e.pss = (e.sig == GOLD);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < LAT + 50) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", tag, done, k);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, a_out, 32'd0);
        check({tag, "_b"}, b_out, 32'd0);
        check({tag, "_op"}, {27'd0, op_out}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_sig"}, signature, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fault = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("idle");

        // Good ALU, vector ordering
        run(1'b0);
        check("e0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
`ifdef ALU_BIST_CORNER_EN
        check("v0_a", a_out, 32'h0);
        check("v0_b", b_out, 32'h0);
        repeat (2) @(negedge clk);
        check("v1_a", a_out, 32'hFFFFFFFF);
        check("v1_b", b_out, 32'hFFFFFFFF);
        repeat (6) @(negedge clk);
        check("v4_a", a_out, SEED);
        check("v4_op", {27'd0, op_out}, 32'd0);
`else
        check("v0_a", a_out, SEED);
        check("v0_b", b_out, bmix(SEED));
        check("v0_op", {27'd0, op_out}, 32'd0);
        repeat (2) @(negedge clk);
        check("v1_a", a_out, lstep(SEED));
`endif
        wait_done("good");

        // Stuck-at-0 on result bit 0
        run(1'b1);
        wait_done("fault");
        check("fault_sig_differs", {31'd0, signature != GOLD}, 32'd1);

        // Restarts while busy are ignored
        run(1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (144) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart");

        // Asynchronous abort mid-run, then a clean rerun
        run(1'b0);
        repeat (99) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0);
        wait_done("rerun");

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
